// File: rtl/freq_pulse_checker_v1.sv
// freq_pulse_checker_v1: checks the divider's frame pulse period and half-rate
// toggle clock, tracks lock, and counts errors with a saturating counter.
module freq_pulse_checker_v1 #(
    parameter int unsigned EXP_PERIOD = 8,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             lclk_fpc_in,
    input  logic             rst_fpc_in,
    input  logic             pulse_fpc_in,
    input  logic             half_clk_fpc_in,
    output logic [CNT_W-1:0] period_fpc_reg_out,
    output logic             period_valid_fpc_reg_out,
    output logic             locked_fpc_reg_out,
    output logic             period_err_fpc_reg_out,
    output logic             toggle_err_fpc_reg_out,
    output logic [7:0]       err_count_fpc_reg_out
);

    localparam int unsigned GOOD_W = 4;
    localparam int unsigned ERR_W  = 8;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  EXP_C    = CNT_W'(EXP_PERIOD);
    localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input stage and edge/toggle history
    logic pulse_q, pulse_qq;
    logic half_q, half_qq;
    logic half_armed_q;
    logic marker_q, marker_d;

    // Measurement and control state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [GOOD_W-1:0]   good_inc;

    // Registered outputs
    logic [CNT_W-1:0]    period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                locked_q, locked_d;
    logic                period_err_q, period_err_d;
    logic                toggle_err_q, toggle_err_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;

    logic                timeout;
    logic                meas_good;

    // All state updates on the rising edge; reset is synchronous
    always_ff @(posedge lclk_fpc_in) begin
        if (rst_fpc_in) begin
            pulse_q        <= 1'b1;
            pulse_qq       <= 1'b1;
            half_q         <= 1'b0;
            half_qq        <= 1'b0;
            half_armed_q   <= 1'b0;
            marker_q       <= 1'b0;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            good_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            period_err_q   <= 1'b0;
            toggle_err_q   <= 1'b0;
            err_count_q    <= '0;
        end else begin
            pulse_q        <= pulse_fpc_in;
            pulse_qq       <= pulse_q;
            half_q         <= half_clk_fpc_in;
            half_qq        <= half_q;
            half_armed_q   <= 1'b1;
            marker_q       <= marker_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_cnt_q     <= good_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            period_err_q   <= period_err_d;
            toggle_err_q   <= toggle_err_d;
            err_count_q    <= err_count_d;
        end
    end

    // Next-state, measurement and error logic
    always_comb begin
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        period_err_d   = 1'b0;
        toggle_err_d   = 1'b0;
        err_count_d    = err_count_q;

        // A multi-cycle low still yields one falling edge, hence one marker
        marker_d  = ~pulse_q & pulse_qq;
        timeout   = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);
        meas_good = (cnt_q == EXP_C);
        good_inc  = good_cnt_q + GOOD_W'(1);

        // Period counter restarts at 1 on a marker, otherwise saturates
        if (marker_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                // First marker only opens the measurement window
                if (marker_q) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (timeout) begin
                    period_err_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (marker_q) begin
                    period_valid_d = 1'b1;
                    period_d       = cnt_q;
                    if (meas_good) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d   = '0;
                        period_err_d = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout) begin
                    period_err_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (marker_q) begin
                    period_valid_d = 1'b1;
                    period_d       = cnt_q;
                    if (!meas_good) begin
                        period_err_d = 1'b1;
                        good_cnt_d   = '0;
                        state_d      = ST_ACQUIRE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                good_cnt_d = '0;
            end
        endcase

        // Half clock must differ from its previous sample every cycle
        toggle_err_d = half_armed_q && (half_q == half_qq);

        // One count per error cycle, regardless of how many strobes fire
        if ((period_err_d || toggle_err_d) && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign period_fpc_reg_out       = period_q;
    assign period_valid_fpc_reg_out = period_valid_q;
    assign locked_fpc_reg_out       = locked_q;
    assign period_err_fpc_reg_out   = period_err_q;
    assign toggle_err_fpc_reg_out   = toggle_err_q;
    assign err_count_fpc_reg_out    = err_count_q;

endmodule

// File: tb/tb_freq_pulse_checker_v1.sv
// Scoreboard bench for freq_pulse_checker_v1: directed divider scenarios plus
// randomized frames, checked against an arithmetic reference model.
module tb_freq_pulse_checker_v1;

    localparam int EXP   = 8;
    localparam int LOCKN = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse;
    logic          half;
    logic [CW-1:0] period_o;
    logic          valid_o;
    logic          locked_o;
    logic          perr_o;
    logic          terr_o;
    logic [7:0]    errc_o;

    always #5 clk = ~clk;

    freq_pulse_checker_v1 #(
        .EXP_PERIOD(EXP),
        .LOCK_COUNT(LOCKN),
        .CNT_W     (CW)
    ) dut (
        .lclk_fpc_in             (clk),
        .rst_fpc_in              (rst),
        .pulse_fpc_in            (pulse),
        .half_clk_fpc_in         (half),
        .period_fpc_reg_out      (period_o),
        .period_valid_fpc_reg_out(valid_o),
        .locked_fpc_reg_out      (locked_o),
        .period_err_fpc_reg_out  (perr_o),
        .toggle_err_fpc_reg_out  (terr_o),
        .err_count_fpc_reg_out   (errc_o)
    );

    typedef struct {
        int edge_n;
        int period;
        bit valid;
        bit perr;
        bit terr;
        bit locked;
        int errc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  edge_n = 0;
    bit  hc     = 1'b0;

    // Reference model: periods from edge-index differences, state as small ints
    bit  ph[$];
    bit  hh[$];
    int  m_state;
    int  m_good;
    int  m_last_load;
    int  m_period;
    int  m_errc;
    int  m_live;

    task automatic model_reset();
        ph = '{1'b1, 1'b1, 1'b1, 1'b1};
        hh = '{1'b0, 1'b0, 1'b0};
        m_state     = 0;
        m_good      = 0;
        m_period    = 0;
        m_errc      = 0;
        m_live      = 0;
        m_last_load = edge_n + 1;
    endtask

    task automatic model_edge(input bit p, input bit h);
        int  cnt;
        bit  mk, to, valid, perr, terr;
        ev_t ev;
        ph.push_back(p);
        void'(ph.pop_front());
        hh.push_back(h);
        void'(hh.pop_front());
        m_live++;
        cnt = edge_n - m_last_load;
        if (cnt > CMAX) cnt = CMAX;
        mk    = (ph[1] == 1'b0) && (ph[0] == 1'b1);
        to    = (m_state != 0) && (cnt == CMAX);
        terr  = (m_live >= 2) && (hh[1] == hh[0]);
        valid = 1'b0;
        perr  = 1'b0;
        if (to) begin
            perr    = 1'b1;
            m_state = 0;
        end else if (mk) begin
            if (m_state == 0) begin
                m_state = 1;
                m_good  = 0;
            end else begin
                valid    = 1'b1;
                m_period = cnt;
                if (cnt == EXP) begin
                    if (m_state == 1) begin
                        m_good++;
                        if (m_good == LOCKN) m_state = 2;
                    end
                end else begin
                    perr    = 1'b1;
                    m_good  = 0;
                    m_state = 1;
                end
            end
        end
        if (mk) m_last_load = edge_n;
        if ((perr || terr) && m_errc < 255) m_errc++;
        if (valid || perr || terr) begin
            ev.edge_n = edge_n;
            ev.period = m_period;
            ev.valid  = valid;
            ev.perr   = perr;
            ev.terr   = terr;
            ev.locked = (m_state == 2);
            ev.errc   = m_errc;
            exp_q.push_back(ev);
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, expv);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model
    task automatic cyc(input bit p, input bit h, input bit r);
        pulse = p;
        half  = h;
        rst   = r;
        @(posedge clk);
        edge_n++;
        if (r) model_reset();
        else   model_edge(p, h);
        #1;
    endtask

    task automatic reset_and_check();
        cyc(1'b1, hc, 1'b1);
        chk("rst_period", int'(period_o), 0);
        chk("rst_valid",  int'(valid_o),  0);
        chk("rst_locked", int'(locked_o), 0);
        chk("rst_perr",   int'(perr_o),   0);
        chk("rst_terr",   int'(terr_o),   0);
        chk("rst_errc",   int'(errc_o),   0);
    endtask

    // One frame: low for low_w cycles then high; half clock toggles unless held
    task automatic frame(input int len, input int low_w, input int hold_pct, input int hold_idx);
        for (int i = 0; i < len; i++) begin
            if (!(i == hold_idx || int'($urandom_range(99)) < hold_pct)) hc = ~hc;
            cyc((i < low_w) ? 1'b0 : 1'b1, hc, 1'b0);
        end
    endtask

    // Monitor: every strobe must match the next expected event exactly
    always @(negedge clk) begin
        if (valid_o === 1'b1 || perr_o === 1'b1 || terr_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe @edge %0d: got v=%0b pe=%0b te=%0b period=%0d required no strobe",
                         edge_n, valid_o, perr_o, terr_o, period_o);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.edge_n != edge_n || (e.valid && e.period != int'(period_o)) ||
                    e.valid != valid_o || e.perr != perr_o || e.terr != terr_o ||
                    e.locked != locked_o || e.errc != int'(errc_o)) begin
                    errors++;
                    $display("FAIL strobe_event: got edge=%0d period=%0d v=%0b pe=%0b te=%0b lk=%0b ec=%0d required edge=%0d period=%0d v=%0b pe=%0b te=%0b lk=%0b ec=%0d",
                             edge_n, period_o, valid_o, perr_o, terr_o, locked_o, errc_o,
                             e.edge_n, e.period, e.valid, e.perr, e.terr, e.locked, e.errc);
                end
            end
        end
    end

    initial begin
        int len, low;
        rst   = 1'b1;
        pulse = 1'b1;
        half  = 1'b0;
        model_reset();

        // Reset state
        reset_and_check();
        reset_and_check();

        // Lock acquisition on clean period-8 stream
        repeat (6) frame(8, 1, 0, -1);
        chk("locked_after_acquire", int'(locked_o), 1);
        chk("errc_clean", int'(errc_o), 0);

        // Short period while locked, then re-lock
        frame(7, 1, 0, -1);
        repeat (6) frame(8, 1, 0, -1);
        chk("relock_after_short", int'(locked_o), 1);

        // Pulse held high: timeout, then re-acquire
        repeat (25) begin
            hc = ~hc;
            cyc(1'b1, hc, 1'b0);
        end
        chk("unlocked_after_timeout", int'(locked_o), 0);
        repeat (7) frame(8, 1, 0, -1);

        // Wide low pulses still give one marker per period
        repeat (4) frame(8, 3, 0, -1);
        chk("locked_wide_low", int'(locked_o), 1);

        // Back-to-back markers
        repeat (4) frame(2, 1, 0, -1);
        repeat (6) frame(8, 1, 0, -1);

        // Half clock stuck low: saturating error count
        hc = 1'b0;
        repeat (38) frame(8, 1, 100, -1);
        chk("errc_saturated", int'(errc_o), 255);
        repeat (3) frame(8, 1, 0, -1);

        // Reset while locked with a few errors pending
        reset_and_check();
        repeat (6) frame(8, 1, 0, -1);
        for (int k = 0; k < 3; k++) frame(8, 1, 0, 4);
        chk("errc_three", int'(errc_o), 3);
        chk("locked_before_reset", int'(locked_o), 1);
        reset_and_check();
        repeat (6) frame(8, 1, 0, -1);
        chk("locked_after_reset", int'(locked_o), 1);

        // Randomized frames, glitches and occasional reset
        repeat (200) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 65)      len = 8;
            else if (r < 75) len = 7;
            else if (r < 82) len = 9;
            else if (r < 88) len = 2;
            else             len = 3 + int'($urandom_range(17));
            low = 1 + int'($urandom_range((len - 2 < 3) ? len - 2 : 3));
            if ($urandom_range(99) < 2) reset_and_check();
            frame(len, low, 3, -1);
        end
        repeat (5) frame(8, 1, 0, -1);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("final_locked", int'(locked_o), (m_state == 2) ? 1 : 0);
        chk("final_errc", int'(errc_o), m_errc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
